// File: rtl/stream_fifo_if.sv
// stream_fifo_if: valid/ready producer and consumer handshakes of one FIFO
interface stream_fifo_if #(
  parameter int NBITS = 16
);
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_data;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_data;
  modport master (output in_val, in_data, out_rdy, input in_rdy, out_val, out_data);
  modport slave  (input in_val, in_data, out_rdy, output in_rdy, out_val, out_data);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO with count, threshold flags, flush and peak monitor
module stream_fifo #(
  parameter int DEPTH     = 8,
  parameter int NBITS     = 16,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  stream_fifo_if.slave         s,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] peak,
  output logic                 almost_full,
  output logic                 almost_empty
);
  localparam int AW = CNT_WIDTH - 1;
  logic [NBITS-1:0]     mem [DEPTH];
  logic [CNT_WIDTH-1:0] w_ptr, r_ptr, nxt_cnt;
  logic                 full, empty, push, pop;
  assign full         = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
  assign empty        = w_ptr == r_ptr;
  assign s.in_rdy     = rst & ~full;
  assign s.out_val    = ~empty;
  assign s.out_data   = empty ? '0 : mem[r_ptr[AW-1:0]];
  assign push         = s.in_val & s.in_rdy;
  assign pop          = s.out_val & s.out_rdy;
  assign count        = w_ptr - r_ptr;
  assign almost_full  = count >= CNT_WIDTH'(AF_LEVEL);
  assign almost_empty = count <= CNT_WIDTH'(AE_LEVEL);
  // occupancy after this edge, feeding the peak monitor
  always_comb begin
    nxt_cnt = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end
  // storage write; a word offered during flush is dropped
  always_ff @(posedge clk) begin
    if (push && !flush) mem[w_ptr[AW-1:0]] <= s.in_data;
  end
  // pointers and peak; reset and flush both empty the FIFO
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      peak  <= '0;
    end else begin
      w_ptr <= w_ptr + CNT_WIDTH'(push);
      r_ptr <= r_ptr + CNT_WIDTH'(pop);
      peak  <= nxt_cnt > peak ? nxt_cnt : peak;
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed checks of stream_fifo, default and custom thresholds
module tb_stream_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] cnt_a, peak_a, cnt_b, peak_b;
  logic       af_a, ae_a, af_b, ae_b;
  int         total = 0;
  int         bad = 0;

  stream_fifo_if #(.NBITS(16)) ifa ();
  stream_fifo_if #(.NBITS(16)) ifb ();

  assign ifb.in_val  = ifa.in_val;
  assign ifb.in_data = ifa.in_data;
  assign ifb.out_rdy = ifa.out_rdy;

  stream_fifo u_dut (
    .clk(clk), .rst(rst), .flush(flush), .s(ifa.slave),
    .count(cnt_a), .peak(peak_a), .almost_full(af_a), .almost_empty(ae_a)
  );

  stream_fifo #(.AF_LEVEL(6), .AE_LEVEL(2)) u_thr (
    .clk(clk), .rst(rst), .flush(flush), .s(ifb.slave),
    .count(cnt_b), .peak(peak_b), .almost_full(af_b), .almost_empty(ae_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifa.in_val = 1'b1;
    ifa.in_data = 16'hDEAD;
    ifa.out_rdy = 1'b0;
    tick();
    tick();
    total++; if (ifa.in_rdy !== 1'b0) begin bad++; $display("FAIL rst_in_rdy got=%0b exp=0", ifa.in_rdy); end
    total++; if (cnt_a !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", cnt_a); end
    total++; if (ifa.out_data !== 16'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0000", ifa.out_data); end
    total++; if (ifa.out_val !== 1'b0) begin bad++; $display("FAIL rst_out_val got=%0b exp=0", ifa.out_val); end
    total++; if (peak_a !== 4'd0) begin bad++; $display("FAIL rst_peak got=%0d exp=0", peak_a); end
    total++; if (ae_a !== 1'b1 || af_a !== 1'b0) begin bad++; $display("FAIL rst_flags got=ae%0b af%0b exp=ae1 af0", ae_a, af_a); end
    rst = 1'b1;
    ifa.in_val = 1'b0;
    #1;
    total++; if (ifa.in_rdy !== 1'b1) begin bad++; $display("FAIL rel_in_rdy got=%0b exp=1", ifa.in_rdy); end
    tick();
    total++; if (cnt_a !== 4'd0 || ifa.out_val !== 1'b0) begin bad++; $display("FAIL rel_nowrite got=cnt%0d val%0b exp=cnt0 val0", cnt_a, ifa.out_val); end
  endtask

  task automatic test_fill_drain();
    ifa.out_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      total++; if (af_a !== (i - 1 >= 7)) begin bad++; $display("FAIL fill_af cnt=%0d got=%0b exp=%0b", i - 1, af_a, (i - 1 >= 7)); end
      ifa.in_val = 1'b1;
      ifa.in_data = 16'(i);
      tick();
    end
    ifa.in_val = 1'b0;
    total++; if (cnt_a !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", cnt_a); end
    total++; if (ifa.in_rdy !== 1'b0) begin bad++; $display("FAIL fill_in_rdy got=%0b exp=0", ifa.in_rdy); end
    total++; if (af_a !== 1'b1) begin bad++; $display("FAIL fill_af_full got=%0b exp=1", af_a); end
    total++; if (peak_a !== 4'd8) begin bad++; $display("FAIL fill_peak got=%0d exp=8", peak_a); end
    ifa.out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if (ifa.out_val !== 1'b1 || ifa.out_data !== 16'(i)) begin bad++; $display("FAIL drain_data got=%h exp=%h", ifa.out_data, 16'(i)); end
      total++; if (ae_a !== (9 - i <= 1)) begin bad++; $display("FAIL drain_ae cnt=%0d got=%0b exp=%0b", 9 - i, ae_a, (9 - i <= 1)); end
      tick();
    end
    ifa.out_rdy = 1'b0;
    total++; if (ifa.out_val !== 1'b0 || ifa.out_data !== 16'h0) begin bad++; $display("FAIL drain_empty got=val%0b data%h exp=val0 data0000", ifa.out_val, ifa.out_data); end
    total++; if (ae_a !== 1'b1 || cnt_a !== 4'd0) begin bad++; $display("FAIL drain_ae_end got=ae%0b cnt%0d exp=ae1 cnt0", ae_a, cnt_a); end
  endtask

  task automatic test_stream();
    ifa.in_val = 1'b1;
    ifa.out_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ifa.in_data = 16'h0100 + 16'(k);
      tick();
      total++; if (ifa.out_val !== 1'b1 || ifa.out_data !== 16'h0100 + 16'(k)) begin bad++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, ifa.out_data, 16'h0100 + 16'(k)); end
      total++; if (cnt_a !== 4'd1) begin bad++; $display("FAIL stream_count k=%0d got=%0d exp=1", k, cnt_a); end
    end
    ifa.in_val = 1'b0;
    tick();
    ifa.out_rdy = 1'b0;
    total++; if (cnt_a !== 4'd0 || ifa.out_val !== 1'b0) begin bad++; $display("FAIL stream_end got=cnt%0d val%0b exp=cnt0 val0", cnt_a, ifa.out_val); end
  endtask

  task automatic test_full_simul();
    logic [15:0] exp_q [8];
    for (int i = 0; i < 8; i++) begin
      ifa.in_val = 1'b1;
      ifa.in_data = 16'h00A0 + 16'(i);
      tick();
    end
    ifa.in_data = 16'hBEEF;
    ifa.out_rdy = 1'b1;
    #1;
    total++; if (ifa.in_rdy !== 1'b0) begin bad++; $display("FAIL full_in_rdy got=%0b exp=0", ifa.in_rdy); end
    tick();
    total++; if (cnt_a !== 4'd7 || ifa.out_data !== 16'h00A1) begin bad++; $display("FAIL full_pop got=cnt%0d data%h exp=cnt7 data00a1", cnt_a, ifa.out_data); end
    ifa.out_rdy = 1'b0;
    tick();
    ifa.in_val = 1'b0;
    total++; if (cnt_a !== 4'd8) begin bad++; $display("FAIL full_accept got=%0d exp=8", cnt_a); end
    for (int i = 0; i < 7; i++) exp_q[i] = 16'h00A1 + 16'(i);
    exp_q[7] = 16'hBEEF;
    ifa.out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (ifa.out_data !== exp_q[i]) begin bad++; $display("FAIL full_drain i=%0d got=%h exp=%h", i, ifa.out_data, exp_q[i]); end
      tick();
    end
    ifa.out_rdy = 1'b0;
    total++; if (cnt_a !== 4'd0) begin bad++; $display("FAIL full_drain_end got=%0d exp=0", cnt_a); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      ifa.in_val = 1'b1;
      ifa.in_data = 16'h0050 + 16'(i);
      tick();
    end
    total++; if (cnt_a !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", cnt_a); end
    flush = 1'b1;
    ifa.in_data = 16'hCAFE;
    ifa.out_rdy = 1'b1;
    tick();
    flush = 1'b0;
    ifa.in_val = 1'b0;
    ifa.out_rdy = 1'b0;
    total++; if (cnt_a !== 4'd0 || peak_a !== 4'd0) begin bad++; $display("FAIL flush_state got=cnt%0d peak%0d exp=cnt0 peak0", cnt_a, peak_a); end
    total++; if (ifa.out_val !== 1'b0 || ifa.out_data !== 16'h0) begin bad++; $display("FAIL flush_out got=val%0b data%h exp=val0 data0000", ifa.out_val, ifa.out_data); end
    tick();
    total++; if (ifa.out_val !== 1'b0) begin bad++; $display("FAIL flush_stays_empty got=%0b exp=0", ifa.out_val); end
    ifa.in_val = 1'b1;
    ifa.in_data = 16'h0077;
    tick();
    ifa.in_val = 1'b0;
    total++; if (ifa.out_data !== 16'h0077 || peak_a !== 4'd1) begin bad++; $display("FAIL flush_next got=data%h peak%0d exp=data0077 peak1", ifa.out_data, peak_a); end
    ifa.out_rdy = 1'b1;
    tick();
    ifa.out_rdy = 1'b0;
  endtask

  task automatic test_thresholds();
    for (int lvl = 0; lvl <= 16; lvl++) begin
      int c;
      c = lvl <= 8 ? lvl : 16 - lvl;
      total++; if (cnt_b !== 4'(c) || cnt_a !== 4'(c)) begin bad++; $display("FAIL thr_count got=a%0d b%0d exp=%0d", cnt_a, cnt_b, c); end
      total++; if (af_b !== (c >= 6) || ae_b !== (c <= 2)) begin bad++; $display("FAIL thr_b cnt=%0d got=af%0b ae%0b exp=af%0b ae%0b", c, af_b, ae_b, (c >= 6), (c <= 2)); end
      total++; if (af_a !== (c >= 7) || ae_a !== (c <= 1)) begin bad++; $display("FAIL thr_a cnt=%0d got=af%0b ae%0b exp=af%0b ae%0b", c, af_a, ae_a, (c >= 7), (c <= 1)); end
      ifa.in_val = lvl < 8;
      ifa.out_rdy = lvl >= 8 && lvl < 16;
      ifa.in_data = 16'h0300 + 16'(lvl);
      if (lvl < 16) tick();
    end
    ifa.in_val = 1'b0;
    ifa.out_rdy = 1'b0;
  endtask

  initial begin
    ifa.in_val = 1'b0;
    ifa.in_data = '0;
    ifa.out_rdy = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_simul();
    test_flush();
    test_thresholds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
